// File: rtl/pe_route_through.sv
// Multi-channel route-through tile: NUM_CH independent valid/ready channels, each
// buffered by a first-word-fall-through FIFO with enable, flush and a transfer counter.
module pe_route_through #(
   parameter int DATA_WIDTH = 130,
   parameter int NUM_CH     = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         ap_start,
   input  logic                         flush,
   input  logic [NUM_CH-1:0]            ch_enable,
   input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
   input  logic [NUM_CH-1:0]            in_valid,
   output logic [NUM_CH-1:0]            in_ready,
   output logic [NUM_CH*DATA_WIDTH-1:0] out_data,
   output logic [NUM_CH-1:0]            out_valid,
   input  logic [NUM_CH-1:0]            out_ready,
   output logic [NUM_CH*CNT_WIDTH-1:0]  xfer_count,
   output logic                         ap_idle
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int OCC_W = PTR_W + 1;
   localparam logic [OCC_W-1:0] DEPTH = OCC_W'(FIFO_DEPTH);

   logic [NUM_CH-1:0] empty;

   // Handshake: a word moves when valid and ready are both high at a rising edge;
   // ready never depends on valid, and both sides are forced low while reset/flush/frozen.
   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic                  run, push, pop;
      logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
      logic [OCC_W-1:0]      occ_q, occ_d;
      logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
      logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

      // Reset gates run so the handshake outputs drop as soon as reset rises.
      assign run          = ap_start & ch_enable[c] & ~flush & ~reset;
      assign in_ready[c]  = run & (occ_q < DEPTH);
      assign out_valid[c] = run & (occ_q != '0);
      assign push         = in_valid[c] & in_ready[c];
      assign pop          = out_valid[c] & out_ready[c];
      assign empty[c]     = (occ_q == '0);

      assign out_data[c*DATA_WIDTH +: DATA_WIDTH] = empty[c] ? '0 : mem_q[rd_ptr_q];
      assign xfer_count[c*CNT_WIDTH +: CNT_WIDTH] = cnt_q;

      always_comb begin
         wr_ptr_d = wr_ptr_q;
         rd_ptr_d = rd_ptr_q;
         occ_d    = occ_q;
         cnt_d    = cnt_q;
         if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
            cnt_d    = '0;
         end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop) begin
               rd_ptr_d = rd_ptr_q + PTR_W'(1);
               cnt_d    = cnt_q + CNT_WIDTH'(1);
            end
            if (push && !pop)      occ_d = occ_q + OCC_W'(1);
            else if (pop && !push) occ_d = occ_q - OCC_W'(1);
         end
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            cnt_q    <= '0;
         end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            cnt_q    <= cnt_d;
         end
      end

      // Storage carries no reset; the empty flag masks stale contents.
      always_ff @(posedge clk) begin
         if (push) mem_q[wr_ptr_q] <= in_data[c*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   assign ap_idle = &empty;

endmodule

// File: tb/tb_pe_route_through.sv
// Bench for pe_route_through: a queue-based model checks every channel each cycle,
// plus directed checks for fill, drain, stream, freeze, flush, counter wrap and reset.
module tb_pe_route_through;

   localparam int DW    = 130;
   localparam int NCH   = 4;
   localparam int DEPTH = 4;
   localparam int CW    = 16;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              ap_start = 1'b0;
   logic              flush = 1'b0;
   logic [NCH-1:0]    ch_enable = '0;
   logic [NCH-1:0]    in_valid = '0;
   logic [NCH-1:0]    out_ready = '0;
   logic [NCH-1:0]    in_ready, out_valid;
   logic [NCH*DW-1:0] in_data = '0;
   logic [NCH*DW-1:0] out_data;
   logic [NCH*CW-1:0] xfer_count;
   logic              ap_idle;

   // Narrow instance with a 4-bit counter for the wrap check.
   logic       ap_start2 = 1'b0;
   logic [0:0] en2 = 1'b1, iv2 = 1'b0, or2 = 1'b0, ir2, ov2;
   logic [7:0] id2 = '0, od2;
   logic [3:0] xc2;
   logic       idle2;

   always #5 clk = ~clk;

   pe_route_through #(.DATA_WIDTH(DW), .NUM_CH(NCH), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
      .clk(clk), .reset(reset), .ap_start(ap_start), .flush(flush), .ch_enable(ch_enable),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .xfer_count(xfer_count), .ap_idle(ap_idle)
   );

   pe_route_through #(.DATA_WIDTH(8), .NUM_CH(1), .FIFO_DEPTH(2), .CNT_WIDTH(4)) dut2 (
      .clk(clk), .reset(reset), .ap_start(ap_start2), .flush(flush), .ch_enable(en2),
      .in_data(id2), .in_valid(iv2), .in_ready(ir2),
      .out_data(od2), .out_valid(ov2), .out_ready(or2),
      .xfer_count(xc2), .ap_idle(idle2)
   );

   int n_vec = 0;
   int n_err = 0;
   logic [DW-1:0] exp_q [NCH][$];
   logic [CW-1:0] cnt_m [NCH];

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_word(input int c, input logic [DW-1:0] w);
      in_data[c*DW +: DW] = w;
   endtask

   function automatic logic [DW-1:0] rnd_word(input int c);
      return {$urandom, $urandom, $urandom, $urandom, 2'(c)};
   endfunction

   // Monitor: compares outputs with the model at mid-cycle, then applies the
   // handshakes that the coming rising edge will perform.
   always @(negedge clk) begin
      bit            e_ir, e_ov, idle_m;
      int            occ;
      logic [DW-1:0] e_od;
      if (reset) begin
         for (int c = 0; c < NCH; c++) begin
            exp_q[c].delete();
            cnt_m[c] = '0;
         end
      end
      idle_m = 1'b1;
      for (int c = 0; c < NCH; c++) if (exp_q[c].size() != 0) idle_m = 1'b0;
      chk("ap_idle", DW'(ap_idle), DW'(idle_m));
      for (int c = 0; c < NCH; c++) begin
         occ  = exp_q[c].size();
         e_ir = ap_start && ch_enable[c] && !flush && !reset && (occ < DEPTH);
         e_ov = ap_start && ch_enable[c] && !flush && !reset && (occ != 0);
         e_od = (occ != 0) ? exp_q[c][0] : '0;
         chk($sformatf("ch%0d in_ready", c), DW'(in_ready[c]), DW'(e_ir));
         chk($sformatf("ch%0d out_valid", c), DW'(out_valid[c]), DW'(e_ov));
         chk($sformatf("ch%0d out_data", c), out_data[c*DW +: DW], e_od);
         chk($sformatf("ch%0d xfer_count", c), DW'(xfer_count[c*CW +: CW]), DW'(cnt_m[c]));
         if (!reset && !flush) begin
            if (e_ov && out_ready[c]) begin
               void'(exp_q[c].pop_front());
               cnt_m[c]++;
            end
            if (e_ir && in_valid[c]) exp_q[c].push_back(in_data[c*DW +: DW]);
         end
      end
      if (!reset && flush) begin
         for (int c = 0; c < NCH; c++) begin
            exp_q[c].delete();
            cnt_m[c] = '0;
         end
      end
   end

   initial begin
      // Reset state
      tick(3);
      chk("rst ap_idle", DW'(ap_idle), DW'(1));
      chk("rst out_valid", DW'(out_valid), DW'(0));
      chk("rst in_ready", DW'(in_ready), DW'(0));
      chk("rst out_data", out_data[DW-1:0], DW'(0));
      chk("rst idle2", DW'(idle2), DW'(1));
      reset = 1'b0;
      tick();

      // Fill ch0 to full with downstream stalled
      ap_start  = 1'b1;
      ch_enable = '1;
      out_ready = '0;
      in_valid  = 4'b0001;
      for (int k = 1; k <= 4; k++) begin
         set_word(0, DW'(k));
         tick();
      end
      in_valid = '0;
      chk("full in_ready0", DW'(in_ready[0]), DW'(0));
      chk("full out_data0", out_data[0 +: DW], DW'(1));
      chk("full ap_idle", DW'(ap_idle), DW'(0));
      chk("full others idle", DW'(out_valid[3:1]), DW'(0));

      // Drain from full with input held: no push while occupancy is 4
      out_ready = 4'b0001;
      in_valid  = 4'b0001;
      set_word(0, DW'(5));
      tick();
      chk("drain xfer0 first", DW'(xfer_count[0 +: CW]), DW'(1));
      chk("drain head after first", out_data[0 +: DW], DW'(2));
      for (int j = 2; j <= 8; j++) begin
         set_word(0, DW'(j + 3));
         tick();
      end
      in_valid  = '0;
      out_ready = '0;
      chk("drain xfer0", DW'(xfer_count[0 +: CW]), DW'(8));
      chk("drain head", out_data[0 +: DW], DW'(9));

      // Stream 1000 cycles, random backpressure on ch1 only
      in_valid = '1;
      for (int i = 0; i < 1000; i++) begin
         for (int c = 0; c < NCH; c++) set_word(c, rnd_word(c));
         out_ready = 4'b1101 | {2'b00, 1'($urandom_range(0, 1)), 1'b0};
         tick();
      end
      chk("stream xfer0", DW'(xfer_count[0*CW +: CW]), DW'(1008));
      chk("stream xfer2", DW'(xfer_count[2*CW +: CW]), DW'(999));
      chk("stream xfer3", DW'(xfer_count[3*CW +: CW]), DW'(999));

      // Build occ[2]=3, then freeze for 5 cycles
      out_ready = 4'b1011;
      for (int i = 0; i < 2; i++) begin
         for (int c = 0; c < NCH; c++) set_word(c, rnd_word(c));
         tick();
      end
      ap_start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         for (int c = 0; c < NCH; c++) set_word(c, rnd_word(c));
         tick();
      end
      chk("freeze in_ready", DW'(in_ready), DW'(0));
      chk("freeze out_valid", DW'(out_valid), DW'(0));
      chk("freeze xfer2", DW'(xfer_count[2*CW +: CW]), DW'(999));
      ap_start  = 1'b1;
      in_valid  = '0;
      out_ready = '1;
      tick(6);
      chk("resume xfer2", DW'(xfer_count[2*CW +: CW]), DW'(1002));
      chk("resume idle", DW'(ap_idle), DW'(1));

      // Flush with occ=2 and xfer_count=7 on ch3
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush1 xfer0", DW'(xfer_count[0 +: CW]), DW'(0));
      in_valid  = 4'b1000;
      out_ready = 4'b1000;
      for (int i = 0; i < 8; i++) begin
         set_word(3, rnd_word(3));
         tick();
      end
      out_ready = '0;
      set_word(3, rnd_word(3));
      tick();
      in_valid = '0;
      chk("preflush xfer3", DW'(xfer_count[3*CW +: CW]), DW'(7));
      chk("preflush out_valid3", DW'(out_valid[3]), DW'(1));
      flush = 1'b1;
      #1;
      chk("flush forces out_valid", DW'(out_valid), DW'(0));
      tick();
      flush = 1'b0;
      #1;
      chk("postflush out_valid3", DW'(out_valid[3]), DW'(0));
      chk("postflush xfer3", DW'(xfer_count[3*CW +: CW]), DW'(0));
      chk("postflush idle", DW'(ap_idle), DW'(1));
      tick();

      // 4-bit counter wraps after 16 pops: 17 pops read back as 1
      ap_start2 = 1'b1;
      iv2 = 1'b1;
      or2 = 1'b1;
      for (int i = 0; i < 18; i++) begin
         id2 = 8'(i + 1);
         tick();
      end
      iv2 = 1'b0;
      or2 = 1'b0;
      chk("wrap xfer", DW'(xc2), DW'(1));
      chk("wrap head", DW'(od2), DW'(18));
      chk("wrap out_valid", DW'(ov2), DW'(1));

      // Asynchronous reset between edges with data buffered
      in_valid = 4'b0001;
      set_word(0, DW'('hA));
      tick();
      set_word(0, DW'('hB));
      tick();
      in_valid = '0;
      chk("prereset out_valid0", DW'(out_valid[0]), DW'(1));
      #2 reset = 1'b1;
      #1;
      chk("async out_valid", DW'(out_valid), DW'(0));
      chk("async in_ready", DW'(in_ready), DW'(0));
      chk("async out_data0", out_data[0 +: DW], DW'(0));
      chk("async idle", DW'(ap_idle), DW'(1));
      chk("async xc2", DW'(xc2), DW'(0));
      chk("async ov2", DW'(ov2), DW'(0));
      tick();
      reset = 1'b0;
      out_ready = '1;
      tick(2);
      chk("post reset xfer0", DW'(xfer_count[0 +: CW]), DW'(0));

      // One-cycle latency through an empty FIFO
      set_word(1, DW'('h77));
      in_valid = 4'b0010;
      #1;
      chk("latency pre", DW'(out_valid[1]), DW'(0));
      tick();
      in_valid = '0;
      chk("latency valid", DW'(out_valid[1]), DW'(1));
      chk("latency data", out_data[1*DW +: DW], DW'('h77));
      tick(2);
      chk("final idle", DW'(ap_idle), DW'(1));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
